// File: rtl/alu_muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL treats op1 as signed; the low half is identical either way
  function automatic logic is_signed_op1(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {carry, hi, lo}; add multiplicand to hi when lo[0] is set,
// then shift the whole accumulator right by one.
// Divide (restoring): acc = {rem, quotient/dividend}; shift left by one,
// trial-subtract the divisor from the remainder and keep it when no borrow.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH:0]  acc,
  input  logic [DATA_WIDTH-1:0]  opnd,
  input  logic                   div_mode,
  output logic [2*DATA_WIDTH:0]  acc_next
);
  localparam int W = DATA_WIDTH;

  logic [W:0]   mul_sum;
  logic [W:0]   rem_shift;
  logic [W+1:0] diff;

  // single combinational step, selected by div_mode
  always_comb begin
    mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rem_shift = {acc[2*W-1:W], acc[W-1]};
    diff      = {1'b0, rem_shift} - {2'b00, opnd};
    acc_next  = {1'b0, mul_sum, acc[W-1:1]};
    if (div_mode) begin
      if (diff[W+1]) acc_next = {rem_shift, acc[W-2:0], 1'b0};
      else           acc_next = {diff[W:0], acc[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Optional feature macro: ALU_MULDIV_FAST_SPECIAL_EN -- when defined, divide
// by zero and signed overflow skip the iterations and finish in one cycle.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for in_valid
//   CALC  | one datapath iteration per cycle, cnt counts down from W
//   DONE  | RESULT presented with out_valid, held until out_ready
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [2:0]            MDctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  md_state_e      state, state_next;
  logic [CW-1:0]  cnt;
  logic [2*W:0]   acc, acc_next;
  logic [W-1:0]   opnd;
  logic [2:0]     op_q;
  logic           neg_q, dz_q, ovf_q;
  logic [W-1:0]   a1_q;
  logic [W-1:0]   result_q;

  logic           a_neg, b_neg, in_neg, in_dz, in_ovf, fast_special;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix, r_fix, final_val;

  // RISC-V defined results for divide by zero and most-negative / -1
  function automatic logic [W-1:0] special_value(input logic [2:0] op,
                                                 input logic [W-1:0] a1,
                                                 input logic dz);
    if (dz) return op[1] ? a1 : {W{1'b1}};
    else    return op[1] ? {W{1'b0}} : a1;
  endfunction

  // operand magnitudes, result sign and special-case detection at accept
  always_comb begin
    a_neg  = is_signed_op1(MDctrl) & ALUop1[W-1];
    b_neg  = is_signed_op2(MDctrl) & ALUop2[W-1];
    a_mag  = a_neg ? -ALUop1 : ALUop1;
    b_mag  = b_neg ? -ALUop2 : ALUop2;
    in_neg = (is_div(MDctrl) && MDctrl[1]) ? a_neg : (a_neg ^ b_neg);
    in_dz  = is_div(MDctrl) && (ALUop2 == '0);
    in_ovf = ((MDctrl == OP_DIV) || (MDctrl == OP_REM)) &&
             (ALUop1 == MOST_NEG) && (ALUop2 == {W{1'b1}});
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
    fast_special = in_dz | in_ovf;
`else
    fast_special = 1'b0;
`endif
  end

  muldiv_iter #(.DATA_WIDTH(W)) u_iter (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (is_div(op_q)),
    .acc_next (acc_next)
  );

  // sign fix-up and result selection for the final iteration
  always_comb begin
    prod_fix = neg_q ? -acc_next[2*W-1:0] : acc_next[2*W-1:0];
    q_fix    = neg_q ? -acc_next[W-1:0]   : acc_next[W-1:0];
    r_fix    = neg_q ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
    if (dz_q || ovf_q)        final_val = special_value(op_q, a1_q, dz_q);
    else if (op_q == OP_MUL)  final_val = prod_fix[W-1:0];
    else if (!is_div(op_q))   final_val = prod_fix[2*W-1:W];
    else if (op_q[1])         final_val = r_fix;
    else                      final_val = q_fix;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state: flush overrides every handshake
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_next = fast_special ? DONE : CALC;
        CALC: if (cnt == CW'(1)) state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // operand capture, iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a1_q     <= '0;
      result_q <= '0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        acc   <= {{(W+1){1'b0}}, is_div(MDctrl) ? a_mag : b_mag};
        opnd  <= is_div(MDctrl) ? b_mag : a_mag;
        cnt   <= CW'(W);
        op_q  <= MDctrl;
        neg_q <= in_neg;
        dz_q  <= in_dz;
        ovf_q <= in_ovf;
        a1_q  <= ALUop1;
        if (fast_special) result_q <= special_value(MDctrl, ALUop1, in_dz);
      end else if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) result_q <= final_val;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);
  assign RESULT    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv (32-bit).
module tb_alu_muldiv;
  localparam int W = 32;
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = W + 1;
`endif
  localparam int OP_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] op1, op2, result;
  logic [2:0]   md;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop1    (op1),
    .ALUop2    (op2),
    .MDctrl    (md),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RESULT    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // accept one op, measure cycles to out_valid, check result, retire it
  task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int n;
    md = f; op1 = a; op2 = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; md = 3'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    check({tag, " latency"}, W'(n), W'(lat));
    check({tag, " result"}, result, exp);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    md = '0; op1 = '0; op2 = '0;
    tick; tick;
    rst = 1'b0;
    check("reset in_ready",  {31'b0, in_ready},  32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset busy",      {31'b0, busy},      32'd0);
    check("reset RESULT",    result,             32'd0);

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, OP_LAT);
    run_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, OP_LAT);
    run_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, OP_LAT);
    run_op("MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, OP_LAT);
    run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, OP_LAT);
    run_op("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, OP_LAT);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       OP_LAT);
    run_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        OP_LAT);
    run_op("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT);
    run_op("DIV -5/0",        3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPEC_LAT);
    run_op("REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5,        SPEC_LAT);
    run_op("REM -5/0",        3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPEC_LAT);
    run_op("DIV min/-1",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT);
    run_op("REM min/-1",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPEC_LAT);
    run_op("DIVU min/max",    3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        OP_LAT);

    // backpressure: hold out_ready low in DONE while offering a new op
    md = 3'b000; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1;
    tick;
    op1 = 32'd9; op2 = 32'd9;
    for (int i = 0; i < 60 && !out_valid; i++) tick;
    for (int i = 0; i < 5; i++) begin
      check("hold RESULT",    result,              32'd12);
      check("hold out_valid", {31'b0, out_valid},  32'd1);
      check("hold in_ready",  {31'b0, in_ready},   32'd0);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("retire in_ready",  {31'b0, in_ready},  32'd1);
    check("retire out_valid", {31'b0, out_valid}, 32'd0);

    // flush at iteration 10 of a DIV
    md = 3'b101; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("calc busy",     {31'b0, busy},     32'd1);
    check("calc in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 9; i++) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush in_ready",  {31'b0, in_ready},  32'd1);
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    check("flush busy",      {31'b0, busy},      32'd0);
    check("flush RESULT",    result,             32'd12);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("flush no out_valid", {31'b0, seen}, 32'd0);

    // synchronous reset in the middle of CALC
    md = 3'b000; op1 = 32'd5; op2 = 32'd6; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst in_ready",  {31'b0, in_ready},  32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst busy",      {31'b0, busy},      32'd0);
    check("rst RESULT",    result,             32'd0);

    run_op("MUL after rst", 3'b000, 32'd5, 32'd6, 32'd30, OP_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative RV32M multiply/divide unit, parametrised in data width. It sits in the execute stage beside the single-cycle ALU and takes over every funct3 of the M extension. It uses a valid/ready handshake on input and output, so the pipeline can stall while the radix-2 shift-add/subtract datapath iterates. It produces one result per operation and holds that result until the consumer accepts it.

## Interface
- DATA_WIDTH, 32: operand and result width; must be even and ≥ 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  abort any in-flight operation (branch mispredict/trap).
- in_valid  in  1  operands and MDctrl are valid.
- in_ready  out  1  unit can accept an operation; equals state==IDLE.
- ALUop1  in  DATA_WIDTH  rs1 operand (multiplicand/dividend).
- ALUop2  in  DATA_WIDTH  rs2 operand (multiplier/divisor).
- MDctrl  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  RESULT is valid.
- out_ready  in  1  consumer accepts RESULT.
- RESULT  out  DATA_WIDTH  registered result.
- busy  out  1  state is CALC or DONE.

## Operation
- States:
  - IDLE: accept on in_valid & in_ready. Latch |ALUop1| and |ALUop2| according to the signedness of MDctrl, the result sign flag and the op. Go to CALC.
  - CALC: run one iteration per cycle, using a log2(DATA_WIDTH)+1-bit counter. After DATA_WIDTH iterations, load RESULT with sign correction and go to DONE.
  - DONE: hold out_valid. On out_ready, return to IDLE.
- Multiply: unsigned shift-add on magnitudes into a 2·DATA_WIDTH product. Negate the product if the sign flag is set.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
  - MULHSU treats ALUop1 as signed and ALUop2 as unsigned.
- Divide: restoring division on magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases follow RISC-V exactly:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return ALUop1.
  - Signed overflow (most-negative ÷ −1): DIV returns ALUop1; REM returns 0.
- Arithmetic is modulo 2^DATA_WIDTH. Internal accumulators are 2·DATA_WIDTH+1 bits.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, RESULT 0, counter 0.
- Latency: an operation accepted in cycle k gives out_valid high from cycle k+DATA_WIDTH+1 (k+33 at 32-bit). It stays high until the cycle in which out_ready is sampled high.
- RESULT and out_valid must not change while out_valid=1 and out_ready=0.
- in_ready is 0 in CALC and DONE. There is no acceptance in the same cycle as output retirement. Throughput is one operation per DATA_WIDTH+2 cycles with out_ready tied high.
- flush in any state: next state is IDLE and out_valid drops next cycle. RESULT keeps its old value and is not presented.
- rst has priority over flush, and flush has priority over the handshakes.
- in_valid with in_ready=0 is ignored. Operands need not be held after acceptance.

## Configuration
- ALU_MULDIV_FAST_SPECIAL_EN:
  - Defined: divide-by-zero and signed overflow are detected in IDLE and go straight to DONE, so out_valid is high in cycle k+1.
  - Undefined: these cases iterate the full DATA_WIDTH cycles and the special value is substituted at the CALC→DONE load.
  - Results are identical either way; only latency differs.

## Structure
- Shared package alu_muldiv_pkg holds:
  - the md_op_e enum of the funct3 encodings;
  - the md_state_e enum (IDLE, CALC, DONE);
  - helper functions is_div(op) and is_signed_op1/op2(op).
- Sub-module muldiv_iter holds the combinational single-iteration step: shift-add for multiply, trial-subtract for divide, parametrised by DATA_WIDTH.
- The top level owns the FSM, counter, operand registers, sign fix-up and handshake.

## Test plan
- MUL 7 × 0xFFFFFFFD → RESULT 0xFFFFFFEB; out_valid first high exactly 33 cycles after acceptance.
- MULH 0x80000000² → 0x40000000. MULHU 0xFFFFFFFF² → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 ÷ 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 100 ÷ 7 → 14; REMU → 2.
- DIV 5 ÷ 0 → 0xFFFFFFFF; REMU 5 ÷ 0 → 5. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM → 0. Latency is 1 cycle with ALU_MULDIV_FAST_SPECIAL_EN defined and 33 cycles without.
- out_ready held low 5 cycles in DONE → RESULT stable, in_ready 0, and new in_valid ignored. out_ready high → IDLE next cycle.
- flush at iteration 10 of a DIV → IDLE next cycle with out_valid never asserted. rst mid-CALC → all outputs at their reset values the next cycle.
